// File: rtl/time_display.sv
// Six-digit multiplexed seven-segment driver for the 12-hour clock (HH MM SS).
// Synchronises inputs, snapshots once per frame, converts to BCD and scans digits.
module time_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 12500000
) (
   input  logic       project_clk,
   input  logic       rst,
   input  logic [3:0] hours,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic       am_pm,
   input  logic       set_h,
   input  logic       set_m,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Tens/ones split by repeated subtraction; six steps cover 0..63.
   function automatic logic [7:0] split_bcd(input logic [5:0] v);
      logic [5:0] r;
      logic [3:0] t;
      r = v;
      t = 4'd0;
      for (int i = 0; i < 6; i++) begin
         if (r >= 6'd10) begin
            r = r - 6'd10;
            t = t + 4'd1;
         end
      end
      return {t, r[3:0]};
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   logic [18:0]   sync1_q, sync2_q;
   logic [16:0]   snap_q, snap_d;
   logic [RW-1:0] ref_cnt_q, ref_cnt_d;
   logic [2:0]    digit_q, digit_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_on_q, blink_on_d;
   logic [5:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic [3:0] snap_h;
   logic [5:0] snap_m, snap_s;
   logic       snap_pm, set_h_s, set_m_s;
   logic [7:0] h_bcd, m_bcd, s_bcd;
   logic       h_bad, m_bad, s_bad;
   logic       ref_tc, blink_tc;
   logic [3:0] val;
   logic       bad, lz, blank;

   assign {snap_h, snap_m, snap_s, snap_pm} = snap_q;
   assign set_h_s = sync2_q[17];
   assign set_m_s = sync2_q[18];

   assign h_bcd = split_bcd({2'b00, snap_h});
   assign m_bcd = split_bcd(snap_m);
   assign s_bcd = split_bcd(snap_s);
   assign h_bad = (snap_h == 4'd0) || (snap_h > 4'd12);
   assign m_bad = snap_m > 6'd59;
   assign s_bad = snap_s > 6'd59;

   always_comb begin
      ref_tc      = (ref_cnt_q == RW'(REFRESH_DIV - 1));
      ref_cnt_d   = ref_tc ? '0 : ref_cnt_q + RW'(1);
      digit_d     = digit_q;
      if (ref_tc) digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
      // Snapshot coincides with the 5->0 wrap so a whole frame shares one capture.
      snap_d      = (ref_tc && digit_q == 3'd5) ? sync2_q[16:0] : snap_q;
      blink_tc    = (blink_cnt_q == BW'(BLINK_DIV - 1));
      blink_cnt_d = blink_tc ? '0 : blink_cnt_q + BW'(1);
      blink_on_d  = blink_tc ? ~blink_on_q : blink_on_q;

      val = 4'd0;
      bad = 1'b0;
      lz  = 1'b0;
      case (digit_q)
         3'd0: begin val = s_bcd[3:0]; bad = s_bad; end
         3'd1: begin val = s_bcd[7:4]; bad = s_bad; end
         3'd2: begin val = m_bcd[3:0]; bad = m_bad; end
         3'd3: begin val = m_bcd[7:4]; bad = m_bad; end
         3'd4: begin val = h_bcd[3:0]; bad = h_bad; end
         3'd5: begin val = h_bcd[7:4]; bad = h_bad; lz = (h_bcd[7:4] == 4'd0); end
         default: ;
      endcase
      blank = !blink_on_q &&
              ((set_h_s && (digit_q == 3'd4 || digit_q == 3'd5)) ||
               (set_m_s && (digit_q == 3'd2 || digit_q == 3'd3)));

      if (blank)    seg_d = SEG_BLANK;
      else if (bad) seg_d = SEG_DASH;
      else if (lz)  seg_d = SEG_BLANK;
      else          seg_d = seg_code(val);
      an_d = ~(6'b000001 << digit_q);
      dp_d = !(digit_q == 3'd0 && snap_pm);
   end

   always_ff @(posedge project_clk or negedge rst) begin
      if (!rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         snap_q      <= '0;
         ref_cnt_q   <= '0;
         digit_q     <= 3'd0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         an_q        <= 6'b111111;
         seg_q       <= SEG_BLANK;
         dp_q        <= 1'b1;
      end else begin
         sync1_q     <= {set_m, set_h, hours, minutes, seconds, am_pm};
         sync2_q     <= sync1_q;
         snap_q      <= snap_d;
         ref_cnt_q   <= ref_cnt_d;
         digit_q     <= digit_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_time_display.sv
// Bench for time_display: directed scenarios plus random inputs, every output
// cycle compared against a frame-level reference model of the display.
module tb_time_display;
   localparam int R = 4;
   localparam int B = 16;
   localparam int HN = 4096;

   logic       project_clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] hours = '0;
   logic [5:0] minutes = '0, seconds = '0;
   logic       am_pm = 1'b0, set_h = 1'b0, set_m = 1'b0;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;

   int n_cmp = 0;
   int n_bad = 0;
   int k = 0;

   int hh [HN];
   int hm [HN];
   int hs [HN];
   int ha [HN];
   int hsh[HN];
   int hsm[HN];

   time_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
      .project_clk(project_clk), .rst(rst),
      .hours(hours), .minutes(minutes), .seconds(seconds), .am_pm(am_pm),
      .set_h(set_h), .set_m(set_m),
      .an(an), .seg(seg), .dp(dp)
   );

   always #5 project_clk = ~project_clk;

   function automatic logic [6:0] digit_seg(int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s at cycle %0d: observed=%b expected=%b", tag, k, obs, exp);
      end
   endtask

   // Expected display for output edge k: which digit, which frame's inputs.
   task automatic check_model();
      int d, f, j, h, m, s, pm, sh, sm, fv, field;
      bit blink_on, bad, blank;
      logic [6:0] es;
      d = ((k - 1) / R) % 6;
      f = (k - 1) / (6 * R);
      if (f == 0) begin
         h = 0; m = 0; s = 0; pm = 0;
      end else begin
         j = f * 6 * R - 2;
         h = hh[j]; m = hm[j]; s = hs[j]; pm = ha[j];
      end
      sh = (k - 2 >= 1) ? hsh[k-2] : 0;
      sm = (k - 2 >= 1) ? hsm[k-2] : 0;
      blink_on = (((k - 1) / B) % 2) == 0;
      field = d / 2;
      fv = (field == 0) ? s : (field == 1) ? m : h;
      bad = (field == 2) ? (h == 0 || h > 12) : (fv > 59);
      blank = !blink_on && ((field == 2 && sh != 0) || (field == 1 && sm != 0));
      if (blank)                es = 7'b1111111;
      else if (bad)             es = 7'b0111111;
      else if (d == 5 && h < 10) es = 7'b1111111;
      else                      es = digit_seg((d % 2 == 1) ? fv / 10 : fv % 10);
      chk("an", {2'b00, an}, {2'b00, ~(6'b000001 << d)});
      chk("seg", {1'b0, seg}, {1'b0, es});
      chk("dp", {7'b0, dp}, {7'b0, !(d == 0 && pm != 0)});
   endtask

   task automatic step();
      @(posedge project_clk);
      k++;
      if (k < HN) begin
         hh[k] = int'(hours); hm[k] = int'(minutes); hs[k] = int'(seconds);
         ha[k] = int'(am_pm); hsh[k] = int'(set_h); hsm[k] = int'(set_m);
      end
      @(negedge project_clk);
      if (k < HN) check_model();
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_reset_vals(string tag);
      chk({tag, "_an"}, {2'b00, an}, 8'h3F);
      chk({tag, "_seg"}, {1'b0, seg}, 8'h7F);
      chk({tag, "_dp"}, {7'b0, dp}, 8'h01);
   endtask

   task automatic set_time(int h, int m, int s, int pm);
      hours = 4'(h); minutes = 6'(m); seconds = 6'(s); am_pm = pm[0];
   endtask

   initial begin
      #1 rst = 1'b0;
      #1 check_reset_vals("reset_initial");
      @(negedge project_clk);
      check_reset_vals("reset_held");
      set_time(12, 34, 56, 1);
      rst = 1'b1;
      k = 0;
      @(posedge project_clk);
      k++;
      hh[1] = 12; hm[1] = 34; hs[1] = 56; ha[1] = 1; hsh[1] = 0; hsm[1] = 0;
      #1 chk("first_edge_an", {2'b00, an}, 8'h3E);
      @(negedge project_clk);
      check_model();

      // Normal 12:34:56 PM display across three frames
      run(3 * 6 * R);

      // Leading-zero suppression 7:05:00 AM
      set_time(7, 5, 0, 0);
      run(2 * 6 * R + 2);

      // Out-of-range hours and minutes
      set_time(0, 60, 42, 1);
      run(2 * 6 * R);
      set_time(13, 63, 60, 0);
      run(2 * 6 * R);

      // Blinking hours, then hours and minutes together
      set_time(12, 34, 56, 0);
      set_h = 1'b1;
      run(4 * B);
      set_m = 1'b1;
      run(4 * B);
      set_h = 1'b0;
      run(2 * B);
      set_m = 1'b0;

      // Snapshot coherence: change 12:59 -> 13:00 while digit 3 is shown
      set_time(10, 12, 59, 0);
      run(2 * 6 * R);
      for (int i = 0; i < 6 * R && (((k - 1) / R) % 6) != 3; i++) step();
      chk("digit3_reached", {2'b00, an}, 8'h37);
      set_time(10, 13, 0, 0);
      run(2 * 6 * R);

      // Random inputs, including out-of-range and blink modes
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 9) == 0)
            set_time($urandom_range(0, 15), $urandom_range(0, 63),
                     $urandom_range(0, 63), $urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0) set_h = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 29) == 0) set_m = $urandom_range(0, 1) != 0;
         step();
      end

      // Asynchronous reset in the middle of a scan
      run(2 * R + 1);
      #2 rst = 1'b0;
      #1 check_reset_vals("reset_mid");
      @(negedge project_clk);
      check_reset_vals("reset_mid_held");
      set_time(9, 8, 7, 1);
      set_h = 1'b0;
      set_m = 1'b0;
      rst = 1'b1;
      k = 0;
      run(3 * 6 * R);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0)
            set_time($urandom_range(0, 15), $urandom_range(0, 63),
                     $urandom_range(0, 63), $urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) set_h = ~set_h;
         if ($urandom_range(0, 19) == 0) set_m = ~set_m;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/time_display.md
# time_display

Downstream display stage for the 12-hour clock counter. Takes the counter's binary `hours`, `minutes`, `seconds` and `am_pm` outputs and drives a six-digit, time-multiplexed, common-anode seven-segment display as HH MM SS. Adds input synchronisation, frame-coherent snapshotting, binary-to-BCD splitting, leading-zero suppression, an out-of-range dash indication and blinking of the field being set. It sits between the counting block and the board display pins.

## Interface
- `REFRESH_DIV`, 50000: `project_clk` cycles each digit stays enabled.
- `BLINK_DIV`, 12500000: `project_clk` cycles per blink half-period.
- `project_clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `hours`  in  4  binary hours; valid range 1–12.
- `minutes`  in  6  binary minutes; valid range 0–59.
- `seconds`  in  6  binary seconds; valid range 0–59.
- `am_pm`  in  1  1 = PM.
- `set_h`  in  1  hours-set mode; the hours field blinks while high.
- `set_m`  in  1  minutes-set mode; the minutes field blinks while high.
- `an`  out  6  digit enables, active-low; bit 0 = seconds ones, bit 5 = hours tens.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- **Input synchronisation:** all inputs pass through 2-flop synchronisers on `project_clk`. Buses are synchronised per bit; tearing is handled by the snapshot stage.
- **Refresh counter:** counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and advances the digit index 0→1→…→5→0.
- **Snapshot:** taken in the same cycle the digit index wraps 5→0. The synchronised `hours`, `minutes`, `seconds` and `am_pm` are captured into snapshot registers. All six digits of one frame therefore come from a single snapshot.
- **Field conversion (from snapshot):**
  - tens = value/10, ones = value%10.
  - Conversion is by compare/subtract; no divider is required.
- **Range check:** a field is out of range if hours is 0 or 13–15, or if minutes or seconds is above 59. Both digits of an out-of-range field show a dash (`seg`=7'b0111111).
- **Leading-zero suppression:** when hours is 1–9, the hours-tens digit is blank (`seg`=7'b1111111) but its `an` bit is still driven. Minutes and seconds keep leading zeros.
- **Decimal-point indicator:** `dp`=0 only while digit 0 is active and the snapshot `am_pm`=1. Otherwise `dp`=1.
- **Blink counter:** counts 0..BLINK_DIV-1 and toggles `blink_on` at terminal count.
  - While synchronised `set_h`=1 and `blink_on`=0, digits 5 and 4 show blank.
  - The same rule applies to `set_m` for digits 3 and 2.
  - Both blinks can be active together and share the same phase.
  - Blanking overrides a dash.
  - `set_h` and `set_m` are not snapshotted; they act as soon as they are synchronised.
- **Segment codes (active-low):** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

## Timing
- **Registered outputs:** `an`, `seg` and `dp` are registered. They reflect the digit index and snapshot one cycle later.
- **Reset (`rst`=0):** applies immediately, independent of the clock.
  - `an`=6'b111111, `seg`=7'b1111111, `dp`=1.
  - Digit index 0, refresh and blink counters 0, `blink_on`=1.
  - Synchronisers and snapshot all 0, so hours reads 0 and the hours field shows dashes.
- **After reset release:** the first rising edge drives `an`=6'b111110. Digit 0 stays enabled for REFRESH_DIV cycles.
- **Digit hand-off:** exactly one `an` bit is low in every cycle outside reset.
- **Frame:** the frame period is 6×REFRESH_DIV cycles.
- **Input-to-display latency:** 2 synchroniser cycles + up to one frame + 1 output cycle. At most 6×REFRESH_DIV+3 cycles.
- **Blink-input latency:** `set_h`/`set_m` to blanking is 3 cycles, provided `blink_on`=0 at that point.
- **Reset mid-frame:** outputs return to the reset values immediately. Scanning restarts at digit 0; no partial frame is preserved.
- **Input change within a frame:** an input that changes during a frame is not shown until the next 5→0 wrap.

## Test plan
- **Reset:** drive `rst`=0 mid-scan → `an`=111111, `seg`=1111111, `dp`=1 at once; after release, `an`=111110 on the first edge.
- **Normal display (REFRESH_DIV=4):** hours=12, minutes=34, seconds=56, am_pm=1, wait 2 frames → digits 5..0 show 1,2,3,4,5,6; `an` steps every 4 cycles; `dp`=0 only on digit 0.
- **Leading-zero suppression:** hours=7, minutes=5, seconds=0, am_pm=0 → digit 5 blank, then 7, 0, 5, 0, 0; `dp`=1 throughout.
- **Out-of-range fields:** hours=0 and minutes=60 → digits 5..2 show `seg`=0111111; seconds digits remain valid.
- **Blink (BLINK_DIV=16):** hours=12, minutes=34, seconds=56, `set_h`=1 → digits 5 and 4 alternate between blank and 1,2 every 16 cycles; adding `set_m`=1 → digits 3 and 2 blank in the same phase; seconds never blink.
- **Snapshot coherence:** change seconds from 59 to 0 and minutes from 12 to 13 while digit 3 is active → the current frame still shows 12:59; the next frame shows 13:00; no mixed frame appears.
